// File: rtl/stream_delay.sv
// stream_delay: holds each valid/ready beat back for a fixed, optionally LFSR-randomised,
// number of cycles before exposing it downstream; the payload itself is never registered.
module stream_delay #(
  parameter bit          StallRandom = 1'b0,
  parameter int unsigned FixedDelay  = 1,
  parameter type         payload_t   = logic,
  parameter logic [15:0] Seed        = 16'hACE1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  payload_t payload_i,
  input  logic     valid_i,
  output logic     ready_o,
  output payload_t payload_o,
  output logic     valid_o,
  input  logic     ready_i
);

  assign payload_o = payload_i;

  if (FixedDelay == 0 && !StallRandom) begin : g_passthrough
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign valid_o        = valid_i;
    assign ready_o        = ready_i;
  end else begin : g_delay
    // Counter must hold FixedDelay + 15 (largest random extra).
    localparam int unsigned CntW     = $clog2(FixedDelay + 16);
    localparam logic [15:0] LfsrTaps = 16'hB400;

    typedef enum logic [1:0] {IDLE, COUNT, PASS} state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] delay_raw;
    logic [CntW-1:0] delay_eff;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;

    // Per-beat delay E, clamped to at least one cycle.
    always_comb begin
      delay_raw = CntW'(FixedDelay);
      if (StallRandom) delay_raw = delay_raw + CntW'(lfsr[3:0]);
      delay_eff = (delay_raw == '0) ? CntW'(1) : delay_raw;
      lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LfsrTaps : 16'h0000);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state <= IDLE;
        cnt   <= '0;
        lfsr  <= Seed;
      end else begin
        unique case (state)
          IDLE: begin
            if (valid_i) begin
              cnt   <= delay_eff - CntW'(1);
              lfsr  <= lfsr_next;
              state <= (delay_eff == CntW'(1)) ? PASS : COUNT;
            end
          end
          COUNT: begin
            cnt <= cnt - CntW'(1);
            if (cnt == CntW'(1)) state <= PASS;
          end
          PASS: begin
            if (valid_i && ready_i) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end

    // Handshake is only opened once the delay has elapsed.
    assign valid_o = (state == PASS) && valid_i && !rst_i;
    assign ready_o = (state == PASS) && ready_i && !rst_i;
  end

endmodule

// File: tb/tb_stream_delay.sv
// tb_stream_delay: directed checks of stream_delay in passthrough, fixed and random-delay configs.
module tb_stream_delay;

  logic       clk;
  logic       rst;
  logic [7:0] payload;
  logic       valid;
  logic       ready;

  logic [7:0] pt_payload, d1_payload, d2_payload, d3_payload, d4_payload, rn_payload;
  logic       pt_valid, d1_valid, d2_valid, d3_valid, d4_valid, rn_valid;
  logic       pt_ready, d1_ready, d2_ready, d3_ready, d4_ready, rn_ready;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stream_delay #(.StallRandom(1'b0), .FixedDelay(0), .payload_t(logic [7:0])) u_pass (
    .clk_i(clk), .rst_i(rst), .payload_i(payload), .valid_i(valid), .ready_o(pt_ready),
    .payload_o(pt_payload), .valid_o(pt_valid), .ready_i(ready));
  stream_delay #(.StallRandom(1'b0), .FixedDelay(1), .payload_t(logic [7:0])) u_d1 (
    .clk_i(clk), .rst_i(rst), .payload_i(payload), .valid_i(valid), .ready_o(d1_ready),
    .payload_o(d1_payload), .valid_o(d1_valid), .ready_i(ready));
  stream_delay #(.StallRandom(1'b0), .FixedDelay(2), .payload_t(logic [7:0])) u_d2 (
    .clk_i(clk), .rst_i(rst), .payload_i(payload), .valid_i(valid), .ready_o(d2_ready),
    .payload_o(d2_payload), .valid_o(d2_valid), .ready_i(ready));
  stream_delay #(.StallRandom(1'b0), .FixedDelay(3), .payload_t(logic [7:0])) u_d3 (
    .clk_i(clk), .rst_i(rst), .payload_i(payload), .valid_i(valid), .ready_o(d3_ready),
    .payload_o(d3_payload), .valid_o(d3_valid), .ready_i(ready));
  stream_delay #(.StallRandom(1'b0), .FixedDelay(4), .payload_t(logic [7:0])) u_d4 (
    .clk_i(clk), .rst_i(rst), .payload_i(payload), .valid_i(valid), .ready_o(d4_ready),
    .payload_o(d4_payload), .valid_o(d4_valid), .ready_i(ready));
  stream_delay #(.StallRandom(1'b1), .FixedDelay(2), .payload_t(logic [7:0])) u_rnd (
    .clk_i(clk), .rst_i(rst), .payload_i(payload), .valid_i(valid), .ready_o(rn_ready),
    .payload_o(rn_payload), .valid_o(rn_valid), .ready_i(ready));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with valid/ready high: delayed instances stay closed, passthrough does not.
  task automatic do_reset();
    rst = 1'b1; valid = 1'b1; ready = 1'b1; payload = 8'h11;
    @(negedge clk);
    check("rst_d3_valid", d3_valid, 0);
    check("rst_d3_ready", d3_ready, 0);
    check("rst_rn_valid", rn_valid, 0);
    check("rst_pt_valid", pt_valid, 1);
    tick();
    valid = 1'b0; ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] m_lfsr;
    int          exp_e;
    int          first;
    int          cyc;
    int          hs;
    bit          done;

    rst = 1'b1; valid = 1'b0; ready = 1'b0; payload = '0;
    tick();
    do_reset();

    // Passthrough: same-cycle combinational path.
    payload = 8'h5A; valid = 1'b1; ready = 1'b1;
    #1;
    check("pt_valid", pt_valid, 1);
    check("pt_ready", pt_ready, 1);
    check("pt_payload", pt_payload, 8'h5A);
    valid = 1'b0; ready = 1'b0;
    #1;
    check("pt_valid_lo", pt_valid, 0);

    // FixedDelay=3: open only in cycle 3.
    do_reset();
    payload = 8'hA3; valid = 1'b1; ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("d3_valid", d3_valid, (c == 3) ? 1 : 0);
      check("d3_ready", d3_ready, (c == 3) ? 1 : 0);
      if (c == 3) check("d3_payload", d3_payload, 8'hA3);
      tick();
    end

    // FixedDelay=1 with backpressure, then async reset while in PASS.
    do_reset();
    payload = 8'h3C; valid = 1'b1; ready = 1'b0;
    @(negedge clk);
    check("d1_c0_valid", d1_valid, 0);
    tick();
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      check("d1_hold_valid", d1_valid, 1);
      check("d1_hold_ready", d1_ready, 0);
      check("d1_hold_payload", d1_payload, 8'h3C);
      tick();
    end
    ready = 1'b1;
    @(negedge clk);
    check("d1_hs_valid", d1_valid, 1);
    check("d1_hs_ready", d1_ready, 1);
    tick();
    ready = 1'b0;
    @(negedge clk);
    check("d1_after_hs_valid", d1_valid, 0);
    tick();
    @(negedge clk);
    check("d1_pass2_valid", d1_valid, 1);
    rst = 1'b1;
    #1;
    check("d1_async_rst_valid", d1_valid, 0);
    check("d1_async_rst_ready", d1_ready, 0);
    valid = 1'b0;
    tick();
    rst = 1'b0;

    // FixedDelay=4, reset mid-count restarts the full delay.
    do_reset();
    payload = 8'h77; valid = 1'b1; ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("d4_pre_valid", d4_valid, 0);
      tick();
    end
    rst = 1'b1;
    #1;
    check("d4_rst_valid", d4_valid, 0);
    tick();
    rst = 1'b0;
    for (int c = 3; c < 8; c++) begin
      @(negedge clk);
      check("d4_restart_valid", d4_valid, (c == 7) ? 1 : 0);
      tick();
    end

    // FixedDelay=2 streaming: one handshake every 3 cycles.
    do_reset();
    payload = 8'h42; valid = 1'b1; ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("d2_valid", d2_valid, (c % 3 == 2) ? 1 : 0);
      if (d2_valid && ready) hs++;
      tick();
    end
    check("d2_handshakes", hs, 3);

    // Random delay: exact E per beat from the LFSR, range [2,17], in-order payloads.
    do_reset();
    m_lfsr = 16'hACE1;
    for (int b = 0; b < 100; b++) begin
      exp_e  = 2 + int'(m_lfsr[3:0]);
      m_lfsr = lfsr_adv(m_lfsr);
      payload = 8'(b); valid = 1'b1;
      cyc = 0; first = -1; done = 1'b0;
      while (!done && cyc < 64) begin
        ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (rn_valid && first < 0) first = cyc;
        if (rn_valid && ready) begin
          check("rnd_payload", rn_payload, 8'(b));
          done = 1'b1;
        end
        tick();
        cyc++;
      end
      if (!done) check("rnd_timeout", 0, 1);
      check("rnd_delay", first, exp_e);
      check("rnd_range", (first >= 2 && first <= 17) ? 1 : 0, 1);
    end
    valid = 1'b0; ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
